dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter: BIG_ENDIAN, 1, byte lane order (1: offset 0 = bits 31:24; 0: offset 0 = bits 7:0).
REQ-002 The block SHALL have port: clk  in  1  single clock, all state changes on rising edge.
REQ-003 The block SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port: req  in  1  CPU access request, sampled only when ready=1.
REQ-005 The block SHALL have port: wr  in  1  1=store, 0=load.
REQ-006 The block SHALL have port: size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 The block SHALL have port: sext  in  1  sign-extend sub-word loads.
REQ-008 The block SHALL have port: addr  in  32  byte address.
REQ-009 The block SHALL have port: wdata  in  32  store data, right-justified.
REQ-010 The block SHALL have port: ready  out  1  idle, request accepted this cycle.
REQ-011 The block SHALL have port: done  out  1  one-cycle completion pulse.
REQ-012 The block SHALL have port: err  out  1  misaligned/illegal flag, valid with done.
REQ-013 The block SHALL have port: rdata  out  32  load result.
REQ-014 The block SHALL have port: sram_cs, sram_oe, sram_we  out  1 each  chip select, output enable, write enable to the memory model.
REQ-015 The block SHALL have port: sram_addr  out  32  word address, {addr[31:2],2'b00}.
REQ-016 The block SHALL have port: sram_din  out  32  write word.
REQ-017 The block SHALL have port: sram_dout  in  32  read word; combinational from the memory model.

Function
REQ-018 All outputs SHALL be registered; ready = (state==IDLE).
REQ-019 States SHALL be IDLE, RD_EN, RD_CAP, WR_SET, WR_PUL, WR_HLD, FIN.
REQ-020 In IDLE with req=1, the block SHALL latch wr/size/sext/addr/wdata and proceed; req while not ready SHALL be ignored.
REQ-021 Misaligned access SHALL skip SRAM: size=11, half with addr[0]=1, or word with addr[1:0]!=0 -> FIN with err=1, rdata unchanged, no cs.
REQ-022 Load path: IDLE->RD_EN (cs=1,oe=1,we=0)->RD_CAP (cs=1,oe=1; sample sram_dout)->FIN; done SHALL be high 3 cycles after the accept edge.
REQ-023 Load extraction: the byte/half at offset addr[1:0] SHALL follow BIG_ENDIAN; zero-extend if sext=0, sign-extend from bit 7/15 if sext=1; word passes unchanged.
REQ-024 Word store path: IDLE->WR_SET (cs=1,oe=0,we=0, addr/din stable)->WR_PUL (we=1)->WR_HLD (we=0, addr/din held)->FIN; done 4 cycles after accept.
REQ-025 Sub-word store SHALL be read-modify-write: RD_EN->RD_CAP (merge wdata[7:0] or [15:0] into sampled word at lane)->WR_SET->WR_PUL->WR_HLD->FIN; done 6 cycles after accept.
REQ-026 sram_addr/sram_din SHALL never change while sram_we=1 or in the cycle before and after it.
REQ-027 FIN SHALL assert done=1 for one cycle with cs=oe=we=0, then return to IDLE; a req sampled in the following IDLE cycle SHALL be accepted (no back-to-back accept in FIN).
REQ-028 Outside the active states listed, sram_cs, sram_oe, sram_we SHALL be 0.
REQ-029 rdata SHALL update only in RD_CAP of a load and hold otherwise; stores SHALL not modify rdata.
REQ-030 err SHALL be 0 whenever done=0.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, ready=1 on the next cycle, done=0, err=0, rdata=0, sram_cs=sram_oe=sram_we=0, sram_addr=0, sram_din=0.
REQ-032 Reset mid-operation SHALL abort without done; a reset in WR_PUL SHALL drop we the next cycle (the write counts as performed).

Verification
REQ-033 Word store addr=0x10, wdata=0xDEADBEEF, then word load 0x10 -> done at +4 and +3 cycles, rdata=0xDEADBEEF, err=0.
REQ-034 With 0x10=0x11223344, BIG_ENDIAN=1: byte load 0x13 sext=0 -> 0x00000044; half load 0x12 -> 0x00003344; byte store 0x11 wdata=0xAA -> memory 0x11AA3344.
REQ-035 With 0x20=0x0000F080: byte load 0x23 sext=1 -> 0xFFFFFF80; half load 0x22 sext=1 -> 0xFFFFF080.
REQ-036 Word load addr=0x12 and any access with size=11 -> done+err at +1 cycle, sram_cs never 1, rdata unchanged.
REQ-037 rst asserted in WR_SET of a store to 0x30 -> no done, no we pulse, 0x30 unchanged, ready=1 after reset.
REQ-038 req held high continuously over three loads -> one accept per IDLE, done pulses spaced 4 cycles, sram_addr/din stable around every we pulse.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns CPU byte/half/word loads and stores into
// timed single-port SRAM cycles, with read-modify-write for sub-word stores.
module dmem_ctrl #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        sram_cs,
    output logic        sram_oe,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_din,
    input  logic [31:0] sram_dout
);

    typedef enum logic [2:0] {
        IDLE, RD_EN, RD_CAP, WR_SET, WR_PUL, WR_HLD, FIN
    } state_e;

    state_e      state_q, state_d;
    logic        wr_q, sext_q;
    logic [1:0]  size_q, off_q;
    logic [15:0] wdata_q;
    logic        ready_q, done_q, err_q, cs_q, oe_q, we_q;
    logic [31:0] rdata_q, addr_q, din_q;

    logic        accept_c, misal_c;
    logic [4:0]  lane_sh_c;
    logic [15:0] lane_c;
    logic [31:0] load_c, mask_c, ins_c, merge_c;

    assign accept_c = (state_q == IDLE) && req;
    assign misal_c  = (size == 2'b11)
                   || ((size == 2'b01) && addr[0])
                   || ((size == 2'b10) && (addr[1:0] != 2'b00));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (misal_c)                      state_d = FIN;
                    else if (wr && (size == 2'b10))   state_d = WR_SET;
                    else                              state_d = RD_EN;
                end
            end
            RD_EN:   state_d = RD_CAP;
            RD_CAP:  state_d = wr_q ? WR_SET : FIN;
            WR_SET:  state_d = WR_PUL;
            WR_PUL:  state_d = WR_HLD;
            WR_HLD:  state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane selection, load extraction and store merge for the sampled word
    always_comb begin
        lane_sh_c = 5'd0;
        if (size_q == 2'b00) begin
            lane_sh_c = BIG_ENDIAN ? {~off_q, 3'b000} : {off_q, 3'b000};
        end else if (size_q == 2'b01) begin
            lane_sh_c = BIG_ENDIAN ? {~off_q[1], 4'b0000} : {off_q[1], 4'b0000};
        end
        lane_c = 16'(sram_dout >> lane_sh_c);
        load_c = sram_dout;
        mask_c = 32'h0000_0000;
        ins_c  = 32'h0000_0000;
        case (size_q)
            2'b00: begin
                load_c = {{24{sext_q & lane_c[7]}}, lane_c[7:0]};
                mask_c = 32'h0000_00FF;
                ins_c  = {24'h00_0000, wdata_q[7:0]};
            end
            2'b01: begin
                load_c = {{16{sext_q & lane_c[15]}}, lane_c};
                mask_c = 32'h0000_FFFF;
                ins_c  = {16'h0000, wdata_q};
            end
            default: ;
        endcase
        merge_c = (sram_dout & ~(mask_c << lane_sh_c)) | (ins_c << lane_sh_c);
    end

    // State, latched request and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            sext_q  <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            wdata_q <= 16'h0000;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cs_q    <= 1'b0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= 32'h0000_0000;
            addr_q  <= 32'h0000_0000;
            din_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            done_q  <= (state_d == FIN);
            // FIN straight out of IDLE only happens for a rejected access
            err_q   <= (state_q == IDLE) && (state_d == FIN);
            cs_q    <= (state_d == RD_EN) || (state_d == RD_CAP) || (state_d == WR_SET)
                    || (state_d == WR_PUL) || (state_d == WR_HLD);
            oe_q    <= (state_d == RD_EN) || (state_d == RD_CAP);
            we_q    <= (state_d == WR_PUL);
            if (accept_c) begin
                wr_q    <= wr;
                size_q  <= size;
                sext_q  <= sext;
                off_q   <= addr[1:0];
                wdata_q <= wdata[15:0];
                if (!misal_c) begin
                    addr_q <= {addr[31:2], 2'b00};
                    if (wr && (size == 2'b10)) din_q <= wdata;
                end
            end
            if (state_q == RD_CAP) begin
                if (wr_q) din_q   <= merge_c;
                else      rdata_q <= load_c;
            end
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign sram_cs   = cs_q;
    assign sram_oe   = oe_q;
    assign sram_we   = we_q;
    assign sram_addr = addr_q;
    assign sram_din  = din_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed cases plus random accesses checked
// against a byte-addressed reference memory model.
module tb_dmem_ctrl;

    localparam bit BE = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ready, done, err, sram_cs, sram_oe, sram_we;
    logic [31:0] rdata, sram_addr, sram_din, sram_dout;

    dmem_ctrl #(.BIG_ENDIAN(BE)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
        .rdata(rdata), .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    // SRAM model: 64 words, combinational read, write on the edge closing a we cycle
    logic [31:0] mem [64] = '{default: 32'h0};
    assign sram_dout = mem[sram_addr[7:2]];
    always @(posedge clk) if (sram_cs && sram_we) mem[sram_addr[7:2]] <= sram_din;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: byte-addressed memory and last load result
    logic [7:0]  rb [256];
    logic [31:0] ref_rdata;

    function automatic logic [31:0] ref_word(input int b);
        if (BE) return {rb[b], rb[b+1], rb[b+2], rb[b+3]};
        return {rb[b+3], rb[b+2], rb[b+1], rb[b]};
    endfunction

    task automatic ref_store_word(input int b, input logic [31:0] wd);
        for (int i = 0; i < 4; i++)
            rb[b+i] = BE ? 8'(wd >> (8*(3-i))) : 8'(wd >> (8*i));
    endtask

    task automatic ref_access(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] wd,
                              output bit mis, output int lat, output int nwe);
        int b;
        logic [7:0]  v8;
        logic [15:0] v16;
        b   = int'(a[7:0]);
        mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        nwe = 0;
        if (mis) begin
            lat = 1;
        end else if (!w) begin
            lat = 3;
            if (sz == 2'd0) begin
                v8 = rb[b];
                ref_rdata = sx ? 32'($signed(v8)) : 32'(v8);
            end else if (sz == 2'd1) begin
                v16 = BE ? {rb[b], rb[b+1]} : {rb[b+1], rb[b]};
                ref_rdata = sx ? 32'($signed(v16)) : 32'(v16);
            end else begin
                ref_rdata = ref_word(b);
            end
        end else begin
            nwe = 1;
            lat = (sz == 2'd2) ? 4 : 6;
            if (sz == 2'd0) begin
                rb[b] = wd[7:0];
            end else if (sz == 2'd1) begin
                rb[b]   = BE ? wd[15:8] : wd[7:0];
                rb[b+1] = BE ? wd[7:0]  : wd[15:8];
            end else begin
                ref_store_word(b, wd);
            end
        end
    endtask

    // we-window stability monitor: addr/din equal one cycle before, during and after we
    bit          in_rst_test = 1'b0;
    logic        p1_we = 1'b0, c_we = 1'b0;
    logic [31:0] p2_addr, p1_addr, c_addr, p2_din, p1_din, c_din;
    always @(negedge clk) begin
        p2_addr = p1_addr; p2_din = p1_din;
        p1_addr = c_addr;  p1_din = c_din;  p1_we = c_we;
        c_addr  = sram_addr; c_din = sram_din; c_we = sram_we;
        if (p1_we && !in_rst_test) begin
            check_eq("stab_addr_pre",  p2_addr, p1_addr);
            check_eq("stab_addr_post", c_addr,  p1_addr);
            check_eq("stab_din_pre",   p2_din,  p1_din);
            check_eq("stab_din_post",  c_din,   p1_din);
        end
    end

    task automatic wait_ready();
        int g = 0;
        while (!ready && g < 16) begin @(negedge clk); g++; end
        check_eq("ready_wait", 32'(ready), 32'd1);
    endtask

    task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
        bit mis, cs_seen, seen_done, addr_cap;
        int exp_lat, exp_we, lat, nwe;
        logic [31:0] first_addr;
        wait_ready();
        if (!ready) return;
        req = 1'b1; wr = w; size = sz; sext = sx; addr = a; wdata = wd;
        ref_access(w, sz, sx, a, wd, mis, exp_lat, exp_we);
        lat = 0; nwe = 0; cs_seen = 0; seen_done = 0; addr_cap = 0; first_addr = 32'h0;
        while (!seen_done && lat < 12) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                req = 1'b0; wr = 1'($urandom); size = 2'($urandom); sext = 1'($urandom);
                addr = $urandom; wdata = $urandom;
            end
            if (sram_cs) begin
                cs_seen = 1;
                if (!addr_cap) begin first_addr = sram_addr; addr_cap = 1; end
            end
            if (sram_we) nwe++;
            if (done) seen_done = 1;
            else check_eq("err_low", 32'(err), 32'd0);
        end
        check_eq("done_latency", 32'(lat), 32'(exp_lat));
        check_eq("err", 32'(err), 32'(mis));
        check_eq("rdata", rdata, ref_rdata);
        check_eq("we_pulses", 32'(nwe), 32'(exp_we));
        check_eq("cs_used", 32'(cs_seen), 32'(!mis));
        if (!mis) check_eq("sram_addr", first_addr, {a[31:2], 2'b00});
        check_eq("mem_word", mem[a[7:2]], ref_word(int'({a[7:2], 2'b00})));
        check_eq("fin_not_ready", 32'(ready), 32'd0);
    endtask

    task automatic reset_in_store(input logic [31:0] a, input logic [31:0] wd, input int stage);
        wait_ready();
        req = 1'b1; wr = 1'b1; size = 2'd2; sext = 1'b0; addr = a; wdata = wd;
        @(negedge clk);
        req = 1'b0;
        check_eq("rst_set_we", 32'(sram_we), 32'd0);
        if (stage == 2) begin
            @(negedge clk);
            check_eq("rst_pul_we", 32'(sram_we), 32'd1);
        end
        in_rst_test = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_we", 32'(sram_we), 32'd0);
        check_eq("rst_cs", 32'(sram_cs), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_sram_addr", sram_addr, 32'd0);
        rst = 1'b0;
        ref_rdata = 32'h0;
        if (stage == 2) ref_store_word(int'(a[7:0]), wd);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_no_done", 32'(done), 32'd0);
            check_eq("rst_no_we", 32'(sram_we), 32'd0);
        end
        in_rst_test = 1'b0;
        check_eq("rst_mem", mem[a[7:2]], ref_word(int'({a[7:2], 2'b00})));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int dones[$];
        logic [31:0] a;
        logic [1:0]  sz;
        for (int i = 0; i < 256; i++) rb[i] = 8'h00;
        ref_rdata = 32'h0;

        repeat (3) @(negedge clk);
        check_eq("reset_ready", 32'(ready), 32'd1);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_err", 32'(err), 32'd0);
        check_eq("reset_rdata", rdata, 32'd0);
        check_eq("reset_cs", 32'(sram_cs), 32'd0);
        check_eq("reset_oe", 32'(sram_oe), 32'd0);
        check_eq("reset_we", 32'(sram_we), 32'd0);
        check_eq("reset_sram_addr", sram_addr, 32'd0);
        check_eq("reset_sram_din", sram_din, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check_eq("dir_word_load", rdata, 32'hDEADBEEF);

        do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
        do_op(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        check_eq("dir_byte_load", rdata, 32'h00000044);
        do_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        check_eq("dir_half_load", rdata, 32'h00003344);
        do_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA);
        check_eq("dir_byte_store", mem[4], 32'h11AA3344);

        do_op(1'b1, 2'd2, 1'b0, 32'h20, 32'h0000F080);
        do_op(1'b0, 2'd0, 1'b1, 32'h23, 32'h0);
        check_eq("dir_byte_sext", rdata, 32'hFFFFFF80);
        do_op(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
        check_eq("dir_half_sext", rdata, 32'hFFFFF080);

        do_op(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
        check_eq("dir_misal_rdata", rdata, 32'hFFFFF080);
        do_op(1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
        do_op(1'b1, 2'd3, 1'b0, 32'h20, 32'h12345678);
        do_op(1'b1, 2'd1, 1'b0, 32'h21, 32'h12345678);

        do_op(1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D);
        reset_in_store(32'h30, 32'h55AA55AA, 1);
        check_eq("dir_rst_set_mem", mem[12], 32'hCAFEF00D);
        reset_in_store(32'h40, 32'h0BADF00D, 2);
        check_eq("dir_rst_pul_mem", mem[16], 32'h0BADF00D);

        // req held high across three loads
        wait_ready();
        req = 1'b1; wr = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h10; wdata = 32'h0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 9) req = 1'b0;
            if (done) dones.push_back(i);
        end
        check_eq("held_done_count", 32'(dones.size()), 32'd3);
        if (dones.size() == 3) begin
            check_eq("held_done0", 32'(dones[0]), 32'd3);
            check_eq("held_gap1", 32'(dones[1] - dones[0]), 32'd4);
            check_eq("held_gap2", 32'(dones[2] - dones[1]), 32'd4);
        end
        check_eq("held_rdata", rdata, ref_word(32'h10));
        ref_rdata = ref_word(32'h10);
        @(negedge clk);
        check_eq("held_no_extra_accept", 32'(ready), 32'd1);

        for (int n = 0; n < 200; n++) begin
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_op(1'($urandom), sz, 1'($urandom), a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
